// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory that serves CPU fetch and
// load/store requests over a req/ready handshake. It inserts LATENCY wait
// states per access and rejects misaligned or out-of-range addresses.
//
// Ports
//   clk     in   1   rising-edge clock
//   resetn  in   1   synchronous reset, asserted HIGH despite the name
//   req     in   1   request, sampled only in IDLE
//   we      in   1   1 = write, 0 = read
//   addr    in   32  byte address; word index = addr[ADDR_W+1:2]
//   wdata   in   32  write data
//   be      in   4   byte enables, be[i] -> wdata[8i+7:8i]
//   rdata   out  32  read data, meaningful while ready = 1
//   ready   out  1   one-cycle completion pulse
//   err     out  1   access rejected, valid with ready
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                access;

  logic                we_q;
  logic                bad_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;

  logic [31:0]         rdata_q;
  logic                err_q;

  logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

  logic                addr_bad;

  // Misaligned byte address, or address bits above the array's reach.
  assign addr_bad = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // req is deliberately ignored here; a held req is taken in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        err_q <= bad_q;
        if (bad_q) begin
          rdata_q <= 32'd0;
        end else if (!we_q) begin
          rdata_q <= mem_q[idx_q];
        end
      end
    end
  end

  // Request fields are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      we_q    <= we;
      bad_q   <= addr_bad;
      idx_q   <= addr[ADDR_W+1:2];
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Storage is never cleared; a write commits only when not held in reset,
  // so a reset arriving before the commit edge discards it.
  always_ff @(posedge clk) begin
    if (!resetn && access && we_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign ready = (state_q == RESP);
  assign err   = err_q & ready;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    bit          e_err;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    bit          e;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        req_v   [3];
  logic [31:0] rdata_v [3];
  logic        ready_v [3];
  logic        err_v   [3];

  int   cyc = 0;
  int   total = 0;
  int   fails = 0;
  int   pulses [3] = '{0, 0, 0};
  exp_t sb [3][$];
  vec_t tbl [15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  mem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
    .clk(clk), .resetn(resetn), .req(req_v[0]), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]));
  mem_responder #(.ADDR_W(10), .LATENCY(0)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_v[1]), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]));
  mem_responder #(.ADDR_W(10), .LATENCY(3)) dut_c (
    .clk(clk), .resetn(resetn), .req(req_v[2]), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]));

  function automatic int lat_of(input int idx);
    case (idx)
      0: return 2;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ready_v[i] === 1'b1) begin
        pulses[i]++;
        if (sb[i].size() == 0) begin
          chk($sformatf("unexpected_ready_dut%0d", i), 32'd1, 32'd0);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("ready_cycle_dut%0d", i), cyc, e.cyc);
          chk($sformatf("err_dut%0d", i), {31'd0, err_v[i]}, {31'd0, e.e});
          if (e.chk_rd) chk($sformatf("rdata_dut%0d", i), rdata_v[i], e.rd);
        end
      end
    end
  end

  task automatic push_exp(input int idx, input bit w, input bit e_err,
                          input logic [31:0] e_rd, input int at);
    exp_t e;
    e.chk_rd = !w || e_err;
    e.rd     = e_err ? 32'd0 : e_rd;
    e.e      = e_err;
    e.cyc    = at;
    sb[idx].push_back(e);
  endtask

  task automatic wait_ready(input int idx, input bit early_drop);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 0 && early_drop) begin
        req_v[idx] = 1'b0;
        addr       = 32'h10;
      end
      if (ready_v[idx] === 1'b1) seen = 1'b1;
    end
    if (!seen) chk($sformatf("ready_timeout_dut%0d", idx), 32'd0, 32'd1);
  endtask

  task automatic access(input int idx, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input bit e_err, input logic [31:0] e_rd, input bit early_drop);
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    req_v[idx] = 1'b1;
    push_exp(idx, w, e_err, e_rd, cyc + lat_of(idx) + 2);
    wait_ready(idx, early_drop);
    req_v[idx] = 1'b0;
  endtask

  // req held high across three reads; each new address is presented during RESP.
  task automatic burst3(input int idx, input logic [31:0] base, input logic [31:0] tag);
    @(negedge clk);
    we = 1'b0; addr = 32'h0; be = 4'hF; wdata = 32'd0;
    req_v[idx] = 1'b1;
    push_exp(idx, 1'b0, 1'b0, tag | 32'h0, cyc + lat_of(idx) + 2);
    for (int j = 0; j < 3; j++) begin
      wait_ready(idx, 1'b0);
      if (j < 2) begin
        addr = 32'(4 * (j + 1));
        push_exp(idx, 1'b0, 1'b0, tag | 32'(j + 1), cyc + lat_of(idx) + 3);
      end
    end
    req_v[idx] = 1'b0;
    if (base != 32'd0) addr = base;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'b0001, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEADBEAA};
    tbl[4]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEADBEAA};
    tbl[6]  = '{1'b1, 32'h12,   32'h11111111, 4'b1111, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h1000, 32'h22222222, 4'b1111, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 1'b0, 32'hDEADBEAA};
    tbl[9]  = '{1'b0, 32'h1000, 32'h0,        4'b1111, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h13,   32'h0,        4'b1111, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 32'h20,   32'h12345678, 4'b1111, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h20,   32'h0,        4'b1111, 1'b0, 32'h12345678};
    tbl[13] = '{1'b1, 32'hFFC,  32'h0A0B0C0D, 4'b1111, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'hFFC,  32'h0,        4'b1111, 1'b0, 32'h0A0B0C0D};

    resetn = 1'b1; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready_dut%0d", i), {31'd0, ready_v[i]}, 32'd0);
      chk($sformatf("reset_err_dut%0d", i),   {31'd0, err_v[i]},   32'd0);
      chk($sformatf("reset_rdata_dut%0d", i), rdata_v[i],          32'd0);
    end

    // Basic writes, byte enables, no-op write, error cases, top word.
    for (int i = 0; i < 15; i++) begin
      access(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].e_err, tbl[i].e_rd, 1'b0);
    end

    // Reset during WAIT of a write: discarded, no ready.
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h55555555; be = 4'hF;
    req_v[0] = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    req_v[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    p0 = pulses[0];
    chk("midreset_rdata", rdata_v[0], 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("midreset_no_ready", {31'd0, ready_v[0]}, 32'd0);
    end
    chk("midreset_pulse_count", 32'(pulses[0] - p0), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h12345678, 1'b0);

    // Back-to-back reads with req held, LATENCY=0 and LATENCY=3.
    for (int i = 1; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        access(i, 1'b1, 32'(4 * j), 32'hA5000000 | 32'(i << 8) | 32'(j), 4'hF,
               1'b0, 32'h0, 1'b0);
      end
      burst3(i, 32'd0, 32'hA5000000 | 32'(i << 8));
    end

    // req dropped and addr changed mid-WAIT: captured address wins, one pulse.
    p0 = pulses[0];
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h12345678, 1'b1);
    repeat (8) @(negedge clk);
    chk("drop_single_pulse", 32'(pulses[0] - p0), 32'd1);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb_empty_dut%0d", i), 32'(sb[i].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
